// File: rtl/pe_cmd_pkg.sv
// Command encodings, image selects and controller state type shared by the
// Cannon sequencer and the processing-element array.
package pe_cmd_pkg;

    localparam logic [2:0] CMD_MAC    = 3'b000;
    localparam logic [2:0] CMD_UP     = 3'b001;
    localparam logic [2:0] CMD_DOWN   = 3'b010;
    localparam logic [2:0] CMD_LEFT   = 3'b011;
    localparam logic [2:0] CMD_RIGHT  = 3'b100;
    localparam logic [2:0] CMD_OVR_AB = 3'b101;
    localparam logic [2:0] CMD_OVR_S  = 3'b110;
    localparam logic [2:0] CMD_CLR    = 3'b111;

    localparam logic IMG_A = 1'b0;
    localparam logic IMG_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_EXEC,
        ST_DONE,
        ST_ERR
    } seq_state_e;

endpackage

// File: rtl/handshake_watchdog.sv
// Counts cycles spent in one handshake phase and flags expiry once the
// count reaches TIMEOUT-1; a TIMEOUT of 0 never expires.
module handshake_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] count_q;

    // Counter saturates at LAST so a stalled phase keeps expiry asserted.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (enable_i && !expired_o) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired_o = (TIMEOUT > 0) && enable_i && (count_q == LAST);

endmodule

// File: rtl/cannon_sequencer.sv
// Broadcasts the clear/load/MAC/shift command sequence of a Cannon matrix
// multiply to an N x N PE torus and runs the ack/ready handshake with it.
module cannon_sequencer
    import pe_cmd_pkg::*;
#(
    parameter int N       = 4,
    parameter int STEP_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [STEP_W-1:0] k_steps,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [STEP_W-1:0] step,
    input  logic [N*N-1:0]    pe_ready,
    output logic              pe_ack,
    output logic [2:0]        command_to_execute,
    output logic              image_to_shift
);

    localparam logic [STEP_W-1:0] ONE = STEP_W'(1);

    seq_state_e        state_q;
    logic [STEP_W-1:0] k_q;
    logic [STEP_W-1:0] step_q;
    logic [2:0]        cmd_q;
    logic              img_q;
    logic              ack_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic allLow;
    logic allHigh;
    logic inWait;
    logic waitMet;
    logic wdExpired;
    logic lastMac;
    logic runOver;

    assign allLow  = ~|pe_ready;
    assign allHigh = &pe_ready;
    assign inWait  = (state_q == ST_ISSUE) || (state_q == ST_EXEC);
    assign waitMet = ((state_q == ST_ISSUE) && allLow) ||
                     ((state_q == ST_EXEC) && allHigh);
    assign lastMac = (step_q == k_q - ONE);
    // The run ends after the load when k is zero, otherwise after the final MAC.
    assign runOver = ((cmd_q == CMD_OVR_AB) && (k_q == '0)) ||
                     ((cmd_q == CMD_MAC) && lastMac);

    handshake_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clear_i  (!inWait || waitMet),
        .enable_i (inWait),
        .expired_o(wdExpired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            step_q  <= '0;
            cmd_q   <= CMD_MAC;
            img_q   <= IMG_A;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        k_q     <= k_steps;
                        step_q  <= '0;
                        cmd_q   <= CMD_CLR;
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (allLow) begin
                        ack_q   <= 1'b0;
                        state_q <= ST_EXEC;
                    end else if (wdExpired) begin
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_ERR;
                    end
                end
                ST_EXEC: begin
                    if (allHigh && runOver) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (allHigh) begin
                        ack_q   <= 1'b1;
                        state_q <= ST_ISSUE;
                        // A non-final MAC is followed by the A-left then B-up shifts.
                        case (cmd_q)
                            CMD_CLR:    cmd_q <= CMD_OVR_AB;
                            CMD_MAC: begin
                                cmd_q  <= CMD_LEFT;
                                img_q  <= IMG_A;
                                step_q <= step_q + ONE;
                            end
                            CMD_LEFT: begin
                                cmd_q <= CMD_UP;
                                img_q <= IMG_B;
                            end
                            default:    cmd_q <= CMD_MAC;
                        endcase
                    end else if (wdExpired) begin
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_ERR;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = error_q;
    assign step               = step_q;
    assign pe_ack             = ack_q;
    assign command_to_execute = cmd_q;
    assign image_to_shift     = img_q;

endmodule

// File: tb/tb_cannon_sequencer.sv
// Scoreboard bench for cannon_sequencer: a delayed-response PE array model,
// an optional instant-response array and a single stuck-PE injection.
module tb_cannon_sequencer;

    localparam int N      = 4;
    localparam int NN     = N * N;
    localparam int STEP_W = 8;
    localparam int TMO    = 16;
    localparam int D      = 3;

    localparam logic [2:0] C_MAC  = 3'b000;
    localparam logic [2:0] C_UP   = 3'b001;
    localparam logic [2:0] C_LEFT = 3'b011;
    localparam logic [2:0] C_OVR  = 3'b101;
    localparam logic [2:0] C_CLR  = 3'b111;

    typedef struct packed {
        logic [2:0]        cmd;
        logic              img;
        logic [STEP_W-1:0] step;
    } op_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic [STEP_W-1:0] k_steps;
    logic              busy;
    logic              done;
    logic              error;
    logic [STEP_W-1:0] step;
    logic [NN-1:0]     pe_ready;
    logic              pe_ack;
    logic [2:0]        command_to_execute;
    logic              image_to_shift;

    logic [NN-1:0] modelReady = '1;
    int            lowCnt[NN];
    logic          instant;
    logic [NN-1:0] stuckMask;

    op_t  expQ[$];
    logic lastImg;
    int   total;
    int   bad;
    int   cyc;

    cannon_sequencer #(
        .N(N),
        .STEP_W(STEP_W),
        .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .k_steps(k_steps),
        .busy(busy),
        .done(done),
        .error(error),
        .step(step),
        .pe_ready(pe_ready),
        .pe_ack(pe_ack),
        .command_to_execute(command_to_execute),
        .image_to_shift(image_to_shift)
    );

    always #5 CLK = ~CLK;

    // Each PE drops ready one cycle after ack rises and raises it D cycles after ack falls.
    always @(posedge CLK) begin
        for (int p = 0; p < NN; p++) begin
            if (pe_ack) begin
                modelReady[p] <= 1'b0;
                lowCnt[p]     <= 0;
            end else if (!modelReady[p]) begin
                if (lowCnt[p] == D - 1) modelReady[p] <= 1'b1;
                else lowCnt[p] <= lowCnt[p] + 1;
            end
        end
    end

    assign pe_ready = instant ? {NN{~pe_ack}} : (modelReady & ~stuckMask);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pushRun(input int k);
        expQ.push_back('{cmd: C_CLR, img: lastImg, step: '0});
        expQ.push_back('{cmd: C_OVR, img: lastImg, step: '0});
        for (int i = 0; i < k; i++) begin
            expQ.push_back('{cmd: C_MAC, img: lastImg, step: STEP_W'(i)});
            if (i < k - 1) begin
                expQ.push_back('{cmd: C_LEFT, img: 1'b0, step: STEP_W'(i + 1)});
                expQ.push_back('{cmd: C_UP, img: 1'b1, step: STEP_W'(i + 1)});
                lastImg = 1'b1;
            end
        end
    endtask

    // Starts a run of k iterations and scores every issued op until done.
    task automatic applyStimulus(input int k, input int injectAt, input int maxCyc, output int cycles);
        logic finished;
        logic prevAck;
        op_t  cur;
        pushRun(k);
        k_steps  = STEP_W'(k);
        start    = 1'b1;
        prevAck  = 1'b0;
        finished = 1'b0;
        cur      = '0;
        cycles   = 0;
        while (!finished && cycles < maxCyc) begin
            @(posedge CLK);
            #1;
            cycles++;
            start = 1'b0;
            if (cycles == injectAt) begin
                start   = 1'b1;
                k_steps = STEP_W'(5);
            end
            if (cycles == 1) checkOutput("start_err_clear", error, 0);
            if (pe_ack && !prevAck) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_op", command_to_execute, 0);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("op_cmd", command_to_execute, cur.cmd);
                    checkOutput("op_img", image_to_shift, cur.img);
                    checkOutput("op_step", step, cur.step);
                end
            end
            if (!pe_ack && prevAck) checkOutput("cmd_hold", command_to_execute, cur.cmd);
            prevAck = pe_ack;
            if (done) begin
                finished = 1'b1;
                checkOutput("done_busy", busy, 0);
                checkOutput("done_error", error, 0);
                checkOutput("done_step", step, (k > 0) ? k - 1 : 0);
                checkOutput("ops_left", expQ.size(), 0);
            end else begin
                checkOutput("busy_run", busy, 1);
            end
        end
        if (!finished) begin
            checkOutput("run_timeout", cycles, maxCyc + 1);
            expQ.delete();
        end else begin
            @(posedge CLK);
            #1;
            checkOutput("done_pulse", done, 0);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ack"}, pe_ack, 0);
        checkOutput({tag, "_cmd"}, command_to_execute, 0);
        checkOutput({tag, "_img"}, image_to_shift, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_error"}, error, 0);
        checkOutput({tag, "_step"}, step, 0);
    endtask

    initial begin
        int c;
        int rises;
        logic prevAck;
        RST       = 1'b1;
        start     = 1'b0;
        k_steps   = '0;
        instant   = 1'b0;
        stuckMask = '0;
        lastImg   = 1'b0;
        total     = 0;
        bad       = 0;
        repeat (3) @(posedge CLK);
        #1;
        checkResetValues("reset");
        RST = 1'b0;
        idle(2);

        applyStimulus(1, -1, 300, cyc);
        idle(4);
        applyStimulus(3, -1, 600, cyc);
        idle(4);
        applyStimulus(0, 3, 300, cyc);
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            if (pe_ack || busy) rises++;
        end
        checkOutput("k0_quiet", rises, 0);

        k_steps = STEP_W'(3);
        start   = 1'b1;
        @(posedge CLK);
        #1;
        start   = 1'b0;
        rises   = pe_ack ? 1 : 0;
        prevAck = pe_ack;
        for (c = 0; c < 100 && rises < 3; c++) begin
            @(posedge CLK);
            #1;
            if (pe_ack && !prevAck) rises++;
            prevAck = pe_ack;
        end
        checkOutput("rst_third_op", rises, 3);
        checkOutput("rst_pre_cmd", command_to_execute, C_MAC);
        checkOutput("rst_pre_img", image_to_shift, lastImg);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checkResetValues("midrst");
        RST     = 1'b0;
        lastImg = 1'b0;
        idle(6);
        applyStimulus(2, -1, 400, cyc);
        idle(4);

        stuckMask = NN'(1) << 5;
        k_steps   = STEP_W'(1);
        start     = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        checkOutput("err_issue_ack", pe_ack, 1);
        checkOutput("err_issue_cmd", command_to_execute, C_CLR);
        c = 0;
        while (pe_ack && c < 50) begin
            @(posedge CLK);
            #1;
            c++;
        end
        checkOutput("err_exec_entry", pe_ack, 0);
        c = 0;
        while (!error && c < 50) begin
            @(posedge CLK);
            #1;
            c++;
        end
        checkOutput("err_latency", c, TMO);
        checkOutput("err_busy", busy, 0);
        checkOutput("err_ack", pe_ack, 0);
        stuckMask = '0;
        idle(3);
        checkOutput("err_sticky", error, 1);
        applyStimulus(1, -1, 300, cyc);
        idle(4);

        instant = 1'b1;
        idle(2);
        applyStimulus(2, -1, 100, cyc);
        checkOutput("instant_cycles", cyc, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cannon_sequencer.md
# cannon_sequencer

Controller that runs a Cannon-style matrix multiply on an N×N torus of `message_passer` processing elements. It broadcasts one 3-bit PE command at a time over the shared command bus and runs the ack/ready handshake with every PE. Sequence: clear, load, then alternate MAC and shift for `k_steps` iterations. It sits between the host/loader logic and the PE array; operand and s_out overwrite buses are driven elsewhere.

## Interface
Parameters:
- `N`, 4: array dimension; the block watches N*N ready lines.
- `STEP_W`, 8: width of the iteration count.
- `TIMEOUT`, 1024: maximum cycles spent waiting in one handshake phase; 0 disables the watchdog.

Ports:
- `CLK`  in  1  clock; all logic on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a run; sampled only in IDLE or ERR.
- `k_steps`  in  STEP_W  number of MAC iterations; captured on accepted `start`.
- `busy`  out  1  high from the cycle after accepted `start` until the cycle `done` or `error` rises.
- `done`  out  1  one-cycle pulse at run completion.
- `error`  out  1  sticky watchdog flag.
- `step`  out  STEP_W  index of the current MAC iteration (0-based).
- `pe_ready`  in  N*N  ready from each PE.
- `pe_ack`  out  1  broadcast ack to all PEs.
- `command_to_execute`  out  3  broadcast PE command.
- `image_to_shift`  out  1  broadcast image select: 0 = A, 1 = B.

## Operation
- Op sequence per run:
  - CLR (111).
  - OVR_AB (101).
  - Then for i = 0..k-1: MAC (000). If i < k-1, also SHIFT_A (LEFT 011, image 0), then SHIFT_B (UP 001, image 1).
  - Total ops: 3k for k ≥ 1; 2 for k = 0 (no MAC).
- `all_low` = NOR of `pe_ready`; `all_high` = AND of `pe_ready`.
- States:
  - IDLE: on `start`, latch `k_steps`, select CLR, go to ISSUE.
  - ISSUE: `pe_ack`=1. On `all_low`, go to EXEC.
  - EXEC: `pe_ack`=0. On `all_high`, select the next op and go to ISSUE. If no op remains, go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
  - ERR: `error`=1, `pe_ack`=0. On `start`, clear `error` and begin a new run, same as from IDLE.
- `command_to_execute` and `image_to_shift` are loaded when ISSUE is entered and held constant through ISSUE and EXEC. For ops without a shift, `image_to_shift` holds its last value.
- `step` increments when a MAC's EXEC completes, unless it was the last MAC.
- Watchdog:
  - Counter clears on every entry to ISSUE or EXEC.
  - When it reaches TIMEOUT-1 while still in that state, go to ERR, drop `busy`, and abandon the op.
- `start` while busy is ignored. `k_steps` changes mid-run have no effect.
- Mixed `pe_ready` (some PEs high, some low) satisfies neither condition, so the block keeps waiting.

## Timing
- Reset values: `pe_ack`=0, `command_to_execute`=000, `image_to_shift`=0, `busy`=0, `done`=0, `error`=0, `step`=0, state IDLE.
- `RST` mid-run: on the next edge the block is in IDLE with the reset values above. PEs are not reset by this block; the next run begins with CLR.
- Accepted `start` at edge t: ISSUE, `pe_ack`=1 and CLR on the bus, visible after t.
- State changes happen on the edge where the wait condition is sampled true. Minimum 2 cycles per op.
- With an instantly responding array, a run takes 1 + 2·ops cycles from `start` to `done`.
- `done` rises in the cycle after the final EXEC completes. `busy` falls in that same cycle.
- Timeout: ERR is entered TIMEOUT cycles after entering the stalled state; `error` rises in the same cycle `busy` falls.

## Structure
- Shared package `pe_cmd_pkg` holds:
  - Command constants CMD_MAC=000, CMD_UP=001, CMD_DOWN=010, CMD_LEFT=011, CMD_RIGHT=100, CMD_OVR_AB=101, CMD_OVR_S=110, CMD_CLR=111.
  - IMG_A=0, IMG_B=1.
  - The controller state enum.
- One sub-module, `handshake_watchdog`: the timeout counter with clear input, enable and expiry output.
- The ready reduction and op selection stay inline.

## Test plan
The bench uses a behavioural PE model per element: ready falls 1 cycle after ack rises, and rises D=3 cycles after ack falls.
- k=1 → command trace 111, 101, 000. One `done` pulse; `step`=0; `busy` high for the whole run.
- k=3 → trace 111, 101, then 000/011(img0)/001(img1) twice, then 000 (9 ops). `step` ends at 2; no shift after the final MAC.
- k=0 → only 111 and 101, then `done`. A `start` pulse mid-run changes nothing.
- Hold one PE's ready at 0 in EXEC with TIMEOUT=16 → `error`=1 and `busy`=0 exactly 16 cycles after EXEC entry; `pe_ack`=0. A subsequent `start` clears `error` and reissues 111.
- Assert `RST` during the third op → next cycle all outputs at reset values. A new `start` then completes normally.
- Instant-response model, k=2 (6 ops) → `done` exactly 13 cycles after `start`.
